bj_game_sequencer: RTL and testbench
====================================

BJ_GAME_SEQUENCER -- requirements
Module: bj_game_sequencer

Interface
REQ-001 SHALL have parameter DECK_SIZE, default 52, number of cards per loaded deck.
REQ-002 SHALL have parameter RESHUFFLE_AT, default 40, cards_used count at or above which a reshuffle is required.
REQ-003 SHALL have parameter DEALER_STAND, default 17, best total at or above which the dealer stands (soft totals included).
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 btn_deal / btn_hit / btn_stand  in  1 each  one-cycle debounced button pulses.
REQ-007 card_req  out  1  request for the next card from the card source.
REQ-008 card_ack  in  1  one-cycle pulse; card_rank is valid in the same cycle.
REQ-009 card_rank  in  4  1=ace, 2..10 pip, 11..13 face; 0 and 14..15 invalid.
REQ-010 shuffle_start  out  1  one-cycle pulse requesting a deck load/shuffle.
REQ-011 shuffle_done  in  1  one-cycle pulse: deck loaded.
REQ-012 state  out  3  IDLE=0, DEAL=1, PLAYER_TURN=2, DEALER_TURN=3, END_GAME=4, LOAD=5.
REQ-013 playerHand, dealerHand  out  5 each  best hand totals, 0..30.
REQ-014 displayState  out  2  LOSE=0, TIE=1, WIN=2, BJ=3; meaningful only in END_GAME.
REQ-015 resetToReshuffle  out  1  deck must be reloaded before the next deal.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 Each hand SHALL track a hard sum (ace=1, faces=10) and an ace-seen flag; best total = hard+10 when an ace is held and hard<=11, otherwise hard.
REQ-018 Card handshake: card_req SHALL rise one cycle after the need arises, stay high until the card_ack cycle, and be low the cycle after card_ack.
REQ-019 The hand total SHALL update on the cycle after card_ack; cards_used (6-bit, saturating at 63) SHALL increment per valid card.
REQ-020 An invalid rank SHALL be discarded without counting, and card_req SHALL reassert the following cycle.
REQ-021 IDLE: on btn_deal, go to LOAD if resetToReshuffle=1, otherwise go to DEAL; btn_hit and btn_stand are ignored.
REQ-022 LOAD: pulse shuffle_start on the entry cycle, then wait for shuffle_done; on shuffle_done, clear cards_used and resetToReshuffle and go to DEAL.
REQ-023 DEAL: request three cards in the order player, dealer, player.
REQ-024 DEAL exit: if player best==21, go to END_GAME with BJ; otherwise go to PLAYER_TURN.
REQ-025 PLAYER_TURN: btn_hit requests one card; btn_stand goes to DEALER_TURN; if both pulse in the same cycle, stand wins.
REQ-026 PLAYER_TURN: buttons are ignored while a card request is outstanding.
REQ-027 PLAYER_TURN, after each hit: best>21 -> END_GAME with LOSE (dealer draws no cards); best==21 -> DEALER_TURN automatically.
REQ-028 DEALER_TURN: request cards while dealer best < DEALER_STAND.
REQ-029 DEALER_TURN resolution: dealer best>21 -> WIN; player > dealer -> WIN; equal -> TIE; otherwise LOSE; then enter END_GAME.
REQ-030 END_GAME: hold state, hands and displayState until btn_deal.
REQ-031 END_GAME on btn_deal: clear both hands to 0, set resetToReshuffle if cards_used >= RESHUFFLE_AT, and go to IDLE.
REQ-032 displayState SHALL be written only on END_GAME entry.
REQ-033 Worst-case totals: player 20+10=30 and dealer 16+10=26; no overflow of the 5-bit hands is permitted.

Reset
REQ-034 On rst: state=IDLE, hands=0, displayState=LOSE, card_req=0, shuffle_start=0, cards_used=0, resetToReshuffle=1.
REQ-035 rst asserted mid-handshake SHALL drop card_req immediately; any card_ack arriving after reset release SHALL be ignored in IDLE.

Verification
REQ-036 Reset then btn_deal -> LOAD with a single shuffle_start pulse; shuffle_done -> DEAL with resetToReshuffle=0 and cards_used=0.
REQ-037 Deal ranks 1, 5, 13 -> playerHand=21, dealerHand=5, END_GAME with displayState=BJ and no further card_req.
REQ-038 Deal 10, 6, 9; btn_hit with rank 5 -> playerHand=24, END_GAME, LOSE, dealerHand stays 6.
REQ-039 Deal 10, 1, 8; btn_stand -> dealer draws rank 6 (soft 17) and stands; 18 vs 17 -> WIN.
REQ-040 btn_hit and btn_stand in the same cycle -> DEALER_TURN with no player card; rank 0 on ack -> discarded, card_req reasserts the following cycle.
REQ-041 Play games until cards_used=40, then btn_deal in END_GAME -> IDLE with resetToReshuffle=1; next btn_deal -> LOAD.

Source files
------------

// File: rtl/bj_game_sequencer.sv
// bj_game_sequencer: blackjack round controller with card handshake, hand scoring and deck-reload tracking
module bj_game_sequencer #(
    parameter int DECK_SIZE    = 52,
    parameter int RESHUFFLE_AT = 40,
    parameter int DEALER_STAND = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_deal,
    input  logic       btn_hit,
    input  logic       btn_stand,
    output logic       card_req,
    input  logic       card_ack,
    input  logic [3:0] card_rank,
    output logic       shuffle_start,
    input  logic       shuffle_done,
    output logic [2:0] state,
    output logic [4:0] playerHand,
    output logic [4:0] dealerHand,
    output logic [1:0] displayState,
    output logic       resetToReshuffle
);
    localparam logic [2:0] S_IDLE = 3'd0, S_DEAL = 3'd1, S_PLAYER = 3'd2, S_DEALER = 3'd3, S_END = 3'd4, S_LOAD = 3'd5;
    localparam logic [1:0] D_LOSE = 2'd0, D_TIE = 2'd1, D_WIN = 2'd2, D_BJ = 2'd3;
    if (RESHUFFLE_AT > DECK_SIZE) begin : g_cfg_check
        $error("RESHUFFLE_AT exceeds DECK_SIZE");
    end
    logic [2:0] r_state, w_next;
    logic [4:0] r_p_hard, r_d_hard, r_p_best, r_d_best, w_val, w_p_hard, w_d_hard;
    logic       r_p_ace, r_d_ace, w_p_ace, w_d_ace;
    logic [5:0] r_cards_used;
    logic [1:0] r_cnt, r_disp, w_disp_n;
    logic       r_card_req, r_shuffle_start, r_rtr, r_hit_pend;
    logic       w_take, w_good, w_to_p, w_hit_go, w_need;
    function automatic logic [4:0] f_best(input logic [4:0] h, input logic a);
        return (a && h <= 5'd11) ? h + 5'd10 : h;
    endfunction
    assign state            = r_state;
    assign card_req         = r_card_req;
    assign shuffle_start    = r_shuffle_start;
    assign playerHand       = r_p_best;
    assign dealerHand       = r_d_best;
    assign displayState     = r_disp;
    assign resetToReshuffle = r_rtr;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    // next-state decision; stand outranks hit, bust/21 outrank both buttons
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (btn_deal) w_next = r_rtr ? S_LOAD : S_DEAL;
            S_LOAD:   if (shuffle_done) w_next = S_DEAL;
            S_DEAL:   if (r_cnt == 2'd3) w_next = (r_p_best == 5'd21) ? S_END : S_PLAYER;
            S_PLAYER: if (r_p_best > 5'd21) w_next = S_END;
                      else if (r_p_best == 5'd21 || (btn_stand && !r_hit_pend)) w_next = S_DEALER;
            S_DEALER: if (!r_card_req && r_d_best >= 5'(DEALER_STAND)) w_next = S_END;
            S_END:    if (btn_deal) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end
    // card need, incoming card scoring and game result
    always_comb begin
        w_take   = r_card_req && card_ack;
        w_good   = w_take && card_rank != 4'd0 && card_rank <= 4'd13;
        w_val    = (card_rank >= 4'd10) ? 5'd10 : {1'b0, card_rank};
        w_to_p   = (r_state == S_DEAL && r_cnt != 2'd1) || r_state == S_PLAYER;
        w_p_hard = r_p_hard + w_val;
        w_d_hard = r_d_hard + w_val;
        w_p_ace  = r_p_ace || card_rank == 4'd1;
        w_d_ace  = r_d_ace || card_rank == 4'd1;
        w_hit_go = r_state == S_PLAYER && w_next == S_PLAYER && btn_hit && !r_hit_pend;
        w_need   = (r_state == S_DEAL && r_cnt != 2'd3) || (r_state == S_PLAYER && (r_hit_pend || w_hit_go)) ||
                   (r_state == S_DEALER && r_d_best < 5'(DEALER_STAND));
        w_disp_n = (r_state == S_DEAL) ? D_BJ : (r_state == S_PLAYER) ? D_LOSE :
                   (r_d_best > 5'd21 || r_p_best > r_d_best) ? D_WIN : (r_p_best == r_d_best) ? D_TIE : D_LOSE;
    end
    // registered outputs, hands, card counter and reshuffle flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_card_req      <= 1'b0;
            r_shuffle_start <= 1'b0;
            r_hit_pend      <= 1'b0;
            r_cards_used    <= 6'd0;
            r_cnt           <= 2'd0;
            r_disp          <= D_LOSE;
            r_rtr           <= 1'b1;
            r_p_hard        <= 5'd0;
            r_d_hard        <= 5'd0;
            r_p_best        <= 5'd0;
            r_d_best        <= 5'd0;
            r_p_ace         <= 1'b0;
            r_d_ace         <= 1'b0;
        end else begin
            r_card_req      <= w_need && !w_take;
            r_shuffle_start <= r_state == S_IDLE && w_next == S_LOAD;
            if (w_hit_go) r_hit_pend <= 1'b1;
            if (w_good) begin
                r_cards_used <= (r_cards_used == 6'd63) ? r_cards_used : r_cards_used + 6'd1;
                if (r_state == S_DEAL) r_cnt <= r_cnt + 2'd1;
                if (r_state == S_PLAYER) r_hit_pend <= 1'b0;
                if (w_to_p) begin
                    r_p_hard <= w_p_hard;
                    r_p_ace  <= w_p_ace;
                    r_p_best <= f_best(w_p_hard, w_p_ace);
                end else begin
                    r_d_hard <= w_d_hard;
                    r_d_ace  <= w_d_ace;
                    r_d_best <= f_best(w_d_hard, w_d_ace);
                end
            end
            if (r_state == S_LOAD && shuffle_done) begin
                r_cards_used <= 6'd0;
                r_rtr        <= 1'b0;
            end
            if (w_next == S_DEAL && r_state != S_DEAL) begin
                r_cnt      <= 2'd0;
                r_hit_pend <= 1'b0;
            end
            if (w_next == S_END && r_state != S_END) r_disp <= w_disp_n;
            if (r_state == S_END && btn_deal) begin
                r_p_hard <= 5'd0;
                r_d_hard <= 5'd0;
                r_p_best <= 5'd0;
                r_d_best <= 5'd0;
                r_p_ace  <= 1'b0;
                r_d_ace  <= 1'b0;
                if (r_cards_used >= 6'(RESHUFFLE_AT)) r_rtr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bj_game_sequencer.sv
// tb_bj_game_sequencer: scoreboard bench for the blackjack round controller
module tb_bj_game_sequencer;
    logic       clk = 1'b0;
    logic       rst, btn_deal, btn_hit, btn_stand, card_ack, shuffle_done;
    logic [3:0] card_rank;
    logic       card_req, shuffle_start, resetToReshuffle;
    logic [2:0] state;
    logic [4:0] playerHand, dealerHand;
    logic [1:0] displayState;
    int n_checks = 0;
    int n_errors = 0;
    typedef struct packed {
        logic [4:0] p;
        logic [4:0] d;
        logic [1:0] ds;
    } exp_t;
    exp_t sb[$];
    logic [2:0] prev_state = 3'd0;
    localparam int LOSE = 0, TIE = 1, WIN = 2, BJ = 3;
    bj_game_sequencer dut (
        .clk(clk), .rst(rst), .btn_deal(btn_deal), .btn_hit(btn_hit), .btn_stand(btn_stand),
        .card_req(card_req), .card_ack(card_ack), .card_rank(card_rank),
        .shuffle_start(shuffle_start), .shuffle_done(shuffle_done), .state(state),
        .playerHand(playerHand), .dealerHand(dealerHand), .displayState(displayState),
        .resetToReshuffle(resetToReshuffle)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // pops the expected result whenever a round reaches END_GAME
    always @(negedge clk) begin
        if (state == 3'd4 && prev_state != 3'd4) begin
            if (sb.size() == 0) check("sb_unexpected_end", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("end_player", int'(playerHand), int'(e.p));
                check("end_dealer", int'(dealerHand), int'(e.d));
                check("end_display", int'(displayState), int'(e.ds));
            end
        end
        prev_state = state;
    end
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic pulse(input int which);
        btn_deal     = (which == 0);
        btn_hit      = (which == 1) || (which == 3);
        btn_stand    = (which == 2) || (which == 3);
        shuffle_done = (which == 4);
        @(negedge clk);
        {btn_deal, btn_hit, btn_stand, shuffle_done} = 4'b0;
    endtask
    task automatic give_card(input logic [3:0] rk);
        int n = 0;
        while (!card_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", int'(card_req), 1);
        card_ack  = 1'b1;
        card_rank = rk;
        @(negedge clk);
        card_ack = 1'b0;
        check("req_drop", int'(card_req), 0);
    endtask
    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (state != s && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("state_wait", int'(state), int'(s));
    endtask
    task automatic tie_game();
        sb.push_back('{p: 5'd20, d: 5'd20, ds: 2'(TIE)});
        pulse(0);
        give_card(4'd10);
        give_card(4'd12);
        give_card(4'd11);
        wait_state(3'd2);
        pulse(2);
        give_card(4'd13);
        wait_state(3'd4);
        pulse(0);
    endtask
    initial begin
        int n;
        rst = 1'b1;
        {btn_deal, btn_hit, btn_stand, card_ack, shuffle_done} = 5'b0;
        card_rank = 4'd0;
        repeat (3) tick();
        check("rst_state", int'(state), 0);
        check("rst_phand", int'(playerHand), 0);
        check("rst_dhand", int'(dealerHand), 0);
        check("rst_disp", int'(displayState), LOSE);
        check("rst_req", int'(card_req), 0);
        check("rst_shuffle", int'(shuffle_start), 0);
        check("rst_rtr", int'(resetToReshuffle), 1);
        rst = 1'b0;
        tick();
        pulse(1);
        pulse(2);
        check("idle_ignores_btns", int'(state), 0);
        pulse(0);
        check("load_entry", int'(state), 5);
        check("shuffle_pulse", int'(shuffle_start), 1);
        tick();
        check("shuffle_single", int'(shuffle_start), 0);
        check("load_hold", int'(state), 5);
        pulse(4);
        check("deal_after_load", int'(state), 1);
        check("rtr_cleared", int'(resetToReshuffle), 0);
        sb.push_back('{p: 5'd21, d: 5'd5, ds: 2'(BJ)});
        give_card(4'd1);
        check("soft_ace", int'(playerHand), 11);
        give_card(4'd5);
        give_card(4'd13);
        wait_state(3'd4);
        n = 0;
        repeat (5) begin
            tick();
            n += int'(card_req);
        end
        check("bj_no_req", n, 0);
        check("bj_hold", int'(state), 4);
        pulse(0);
        check("end_to_idle", int'(state), 0);
        check("clear_phand", int'(playerHand), 0);
        check("clear_dhand", int'(dealerHand), 0);
        check("no_reshuffle_3", int'(resetToReshuffle), 0);
        sb.push_back('{p: 5'd24, d: 5'd6, ds: 2'(LOSE)});
        pulse(0);
        check("deal_direct", int'(state), 1);
        give_card(4'd10);
        give_card(4'd6);
        give_card(4'd9);
        wait_state(3'd2);
        check("player_19", int'(playerHand), 19);
        pulse(1);
        give_card(4'd5);
        wait_state(3'd4);
        n = 0;
        repeat (4) begin
            tick();
            n += int'(card_req);
        end
        check("bust_no_dealer_req", n, 0);
        check("bust_dealer_hold", int'(dealerHand), 6);
        pulse(0);
        sb.push_back('{p: 5'd18, d: 5'd17, ds: 2'(WIN)});
        pulse(0);
        give_card(4'd10);
        give_card(4'd1);
        give_card(4'd8);
        wait_state(3'd2);
        check("dealer_soft11", int'(dealerHand), 11);
        pulse(2);
        give_card(4'd6);
        wait_state(3'd4);
        pulse(0);
        sb.push_back('{p: 5'd18, d: 5'd18, ds: 2'(TIE)});
        pulse(0);
        give_card(4'd9);
        give_card(4'd10);
        give_card(4'd9);
        wait_state(3'd2);
        pulse(3);
        check("both_to_dealer", int'(state), 3);
        check("both_no_player_card", int'(playerHand), 18);
        give_card(4'd0);
        check("bad_rank_discard", int'(dealerHand), 10);
        tick();
        check("req_reassert", int'(card_req), 1);
        give_card(4'd8);
        wait_state(3'd4);
        pulse(0);
        for (int g = 0; g < 5; g++) begin
            tie_game();
            check("below_reshuffle", int'(resetToReshuffle), 0);
        end
        sb.push_back('{p: 5'd20, d: 5'd19, ds: 2'(WIN)});
        pulse(0);
        give_card(4'd10);
        give_card(4'd10);
        give_card(4'd2);
        wait_state(3'd2);
        pulse(1);
        give_card(4'd8);
        tick();
        check("hit_to_20_stays", int'(state), 2);
        pulse(2);
        give_card(4'd9);
        wait_state(3'd4);
        pulse(0);
        check("idle_at_40", int'(state), 0);
        check("reshuffle_at_40", int'(resetToReshuffle), 1);
        pulse(0);
        check("reload_entry", int'(state), 5);
        check("reload_pulse", int'(shuffle_start), 1);
        pulse(4);
        check("reload_rtr", int'(resetToReshuffle), 0);
        n = 0;
        while (!card_req && n < 20) begin
            tick();
            n++;
        end
        check("mid_req_up", int'(card_req), 1);
        rst = 1'b1;
        #1;
        check("async_req_drop", int'(card_req), 0);
        check("async_state", int'(state), 0);
        tick();
        rst = 1'b0;
        card_ack = 1'b1;
        card_rank = 4'd5;
        tick();
        card_ack = 1'b0;
        tick();
        check("stray_ack_state", int'(state), 0);
        check("stray_ack_hand", int'(playerHand), 0);
        check("stray_ack_req", int'(card_req), 0);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
